// File: rtl/sc_fifo_pkg.sv
// sc_fifo_pkg: shared default widths and depth helper for the sc_fifo slice.
package sc_fifo_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 3;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/sc_fifo_if.sv
// sc_fifo_if: producer/consumer bundle for sc_fifo; ovf/udf exist only with SCFIFO_ERR_FLAGS_EN.
interface sc_fifo_if
    import sc_fifo_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);

    logic [DW-1:0] din;
    logic          write;
    logic [DW-1:0] dout;
    logic          read;
    logic [AW-1:0] wc;
    logic [AW-1:0] rc;
    logic [AW-1:0] dc;
    logic          full;
    logic          empty;
`ifdef SCFIFO_ERR_FLAGS_EN
    logic          ovf;
    logic          udf;

    modport master (
        output din, write, read,
        input  dout, wc, rc, dc, full, empty, ovf, udf
    );

    modport slave (
        input  din, write, read,
        output dout, wc, rc, dc, full, empty, ovf, udf
    );
`else
    modport master (
        output din, write, read,
        input  dout, wc, rc, dc, full, empty
    );

    modport slave (
        input  din, write, read,
        output dout, wc, rc, dc, full, empty
    );
`endif

endinterface

// File: rtl/sc_fifo_ram.sv
// sc_fifo_ram: 2^AW x DW simple dual-port RAM, sync write, registered read with enable.
module sc_fifo_ram
    import sc_fifo_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [depth(AW)];
    logic [DW-1:0] r_rdata;

    // storage is deliberately left unreset so it can map onto RAM macros
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // read register clears on reset and holds between accepted reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sc_fifo.sv
// sc_fifo: single-clock FIFO, capacity 2^AW-1, registered dout; SCFIFO_ERR_FLAGS_EN adds sticky ovf/udf.
module sc_fifo
    import sc_fifo_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    sc_fifo_if.slave bus
);

    localparam logic [AW-1:0] FULL_CNT = AW'(depth(AW) - 1);

    logic [AW-1:0] r_wc;
    logic [AW-1:0] r_rc;
    logic [AW-1:0] r_dc;
    logic          w_full;
    logic          w_empty;
    logic          w_we;
    logic          w_re;

    assign w_full  = r_dc == FULL_CNT;
    assign w_empty = r_dc == '0;
    assign w_we    = bus.write & ~w_full;
    assign w_re    = bus.read & ~w_empty;

    // pointers wrap naturally at 2^AW; count moves only on unbalanced traffic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wc <= '0;
            r_rc <= '0;
            r_dc <= '0;
        end else begin
            r_wc <= w_we ? r_wc + 1'b1 : r_wc;
            r_rc <= w_re ? r_rc + 1'b1 : r_rc;
            r_dc <= (w_we & ~w_re) ? r_dc + 1'b1 : (~w_we & w_re) ? r_dc - 1'b1 : r_dc;
        end
    end

    sc_fifo_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_wc),
        .i_wdata (bus.din),
        .i_re    (w_re),
        .i_raddr (r_rc),
        .o_rdata (bus.dout)
    );

    assign bus.wc    = r_wc;
    assign bus.rc    = r_rc;
    assign bus.dc    = r_dc;
    assign bus.full  = w_full;
    assign bus.empty = w_empty;

`ifdef SCFIFO_ERR_FLAGS_EN
    logic r_ovf;
    logic r_udf;

    // sticky on raw requests so callers that gate externally never see a set flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (bus.write & w_full);
            r_udf <= r_udf | (bus.read & w_empty);
        end
    end

    assign bus.ovf = r_ovf;
    assign bus.udf = r_udf;
`endif

endmodule

// File: tb/tb_sc_fifo.sv
// tb_sc_fifo: scoreboard bench for sc_fifo against a queue-based reference model.
module tb_sc_fifo;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int N  = 8;
    localparam int CAP = N - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    int            q[$];
    logic [DW-1:0] exp_q[$];
    int            mwc = 0;
    int            mrc = 0;
    logic [DW-1:0] mdout = '0;
    bit            movf = 1'b0;
    bit            mudf = 1'b0;

    sc_fifo_if #(.DW(DW), .AW(AW)) bus ();

    sc_fifo #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_q.delete();
        mwc = 0;
        mrc = 0;
        mdout = '0;
        movf = 1'b0;
        mudf = 1'b0;
    endtask

    // drive one cycle at negedge; model the edge from the pre-edge state
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
        bit was_full;
        bit was_empty;
        bus.write = w;
        bus.din   = d;
        bus.read  = r;
        @(posedge clk);
        was_full  = q.size() == CAP;
        was_empty = q.size() == 0;
        if (w && was_full) movf = 1'b1;
        if (r && was_empty) mudf = 1'b1;
        if (r && !was_empty) begin
            mdout = DW'(q.pop_front());
            exp_q.push_back(mdout);
            mrc = (mrc + 1) % N;
        end
        if (w && !was_full) begin
            q.push_back(int'(d));
            mwc = (mwc + 1) % N;
        end
        @(negedge clk);
        bus.write = 1'b0;
        bus.read  = 1'b0;
    endtask

    // monitor: compare state every cycle, pop scoreboard when a read was accepted
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dc", 32'(bus.dc), 32'(q.size()));
            chk("wc", 32'(bus.wc), 32'(mwc));
            chk("rc", 32'(bus.rc), 32'(mrc));
            chk("full", 32'(bus.full), 32'(q.size() == CAP));
            chk("empty", 32'(bus.empty), 32'(q.size() == 0));
`ifdef SCFIFO_ERR_FLAGS_EN
            chk("ovf", 32'(bus.ovf), 32'(movf));
            chk("udf", 32'(bus.udf), 32'(mudf));
`endif
            if (exp_q.size() > 0) chk("dout_rd", 32'(bus.dout), 32'(exp_q.pop_front()));
            else chk("dout_hold", 32'(bus.dout), 32'(mdout));
        end
    end

    initial begin
        bus.write = 1'b0;
        bus.read  = 1'b0;
        bus.din   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_dc", 32'(bus.dc), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;

        // fill past capacity with caller-side gating
        for (int i = 0; i < 10; i++) step(q.size() != CAP, DW'(8'h11 + i), 1'b0);
        chk("fill_dc", 32'(bus.dc), 32'd7);
        chk("fill_wc", 32'(bus.wc), 32'd7);
        chk("fill_full", 32'(bus.full), 32'd1);
        // ungated write while full is dropped
        step(1'b1, 8'hEE, 1'b0);

        // drain past empty
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        chk("drain_dout", 32'(bus.dout), 32'h17);
        chk("drain_rc", 32'(bus.rc), 32'd7);

        // pointer wrap, twice
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h21 + 8'h10 * k + i), 1'b0);
            for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        end
        chk("wrap_wc", 32'(bus.wc), 32'd1);
        chk("wrap_rc", 32'(bus.rc), 32'd1);

        // simultaneous read/write at dc=3, then at empty
        for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h3A + i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h40, 1'b1);
        chk("rw_dc", 32'(bus.dc), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 8'h44, 1'b1);
        chk("rw_empty_dc", 32'(bus.dc), 32'd1);
        chk("rw_empty_dout", 32'(bus.dout), 32'h40);
        step(1'b1, 8'h45, 1'b1);

        // async reset between edges with data stored
        for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h50 + i), 1'b0);
        chk("pre_rst_dc", 32'(bus.dc), 32'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_dc", 32'(bus.dc), 32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        chk("arst_dout", 32'(bus.dout), 32'd0);
        chk("arst_wc", 32'(bus.wc), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        @(negedge clk);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("post_rst_dout", 32'(bus.dout), 32'h55);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int mode;
            mode = int'($urandom_range(0, 99));
            step(mode < 55 ? 1'b1 : ($urandom_range(0, 3) == 0), DW'($urandom), mode >= 45 ? 1'b1 : ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_fifo.md
Name: sc_fifo

Overview:
Single-clock synchronous FIFO: circular buffer of 2^AW entries with registered read data. Exposes write pointer, read pointer and occupancy count. Used as a general-purpose rate/elasticity buffer between producer and consumer logic in one clock domain.

Parameters:
DW, 8, data width in bits.
AW, 3, address width; storage array has 2^AW entries; usable capacity 2^AW-1 (7 by default).

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
din  input  DW  write data.
write  input  1  write request; sampled on rising clk.
dout  output  DW  registered read data.
read  input  1  read request; sampled on rising clk.
wc  output  AW  write pointer (next slot to be written).
rc  output  AW  read pointer (next slot to be read).
dc  output  AW  data count, number of stored words, 0..2^AW-1.
full  output  1  dc == 2^AW-1.
empty  output  1  dc == 0.

Behaviour:
- Reset: rst_n low asynchronously clears wc=0, rc=0, dc=0, dout=0. full=0 and empty=1 while in reset. Memory contents are not reset.
- Reset asserted mid-operation discards all stored data. The FIFO is empty on the first edge after rst_n deasserts.
- Effective write: we = write & ~full. Effective read: re = read & ~empty. The FIFO gates requests internally. Callers may additionally gate them; double gating is harmless.
- On a rising edge with we: mem[wc] <= din; wc <= wc+1, modulo 2^AW (wraps 7->0).
- On a rising edge with re: dout <= mem[rc]; rc <= rc+1, modulo 2^AW. dout holds its value when there is no effective read.
- Read latency: data is valid on dout one cycle after the edge on which read was accepted.
- Count update: dc <= dc + we - re. Simultaneous we and re leave dc unchanged, and both pointers advance.
- Simultaneous read and write while empty: only the write takes effect. The read is ignored; dc becomes 1.
- Simultaneous read and write while full: only the read takes effect. The write is dropped; dc becomes 2^AW-2.
- Write while full is ignored: no state change, data lost.
- Read while empty is ignored: dout, rc and dc unchanged.
- full and empty are combinational decodes of registered dc, so there are no glitches from inputs.
- A word written on edge N may be read on edge N+1 or later. There is no same-cycle bypass.

Optional Feature:
Macro SCFIFO_ERR_FLAGS_EN.
- Defined: adds two output ports, ovf and udf, each 1 bit.
  - ovf is a sticky flag. It is set on any edge with write & full, and cleared only by rst_n.
  - udf is a sticky flag. It is set on any edge with read & empty, and cleared only by rst_n.
- Not defined: the ports and their logic are absent. Dropped requests are silent.

Decomposition:
- Package sc_fifo_pkg holds default widths (DW_DEF=8, AW_DEF=3) and a function depth(aw) returning 2^aw.
- One natural sub-module: sc_fifo_ram, a 2^AW x DW simple dual-port RAM. It has a synchronous write port and a synchronous registered read port with read enable.
- Pointer, count and flag logic stay in sc_fifo.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles, then release -> wc=rc=dc=0, empty=1, full=0, dout=0.
2. Fill past capacity: write 0x11..0x1A on 10 consecutive cycles with write gated by ~full.
   - After 7 writes: dc=7, full=1, wc=7.
   - Remaining 3 writes are dropped; with SCFIFO_ERR_FLAGS_EN, ovf stays 0 when gated.
3. Drain: assert read for 10 cycles.
   - dout sequence is 0x11..0x17, each valid one cycle after acceptance.
   - empty=1 and dc=0 after 7 reads; rc=7; dout then holds 0x17.
4. Pointer wrap: write 0x21..0x25 (wc 7->0..4), then read 5 -> dout 0x21..0x25, rc wraps 7->4, empty=1. Repeat with 0x31..0x35 -> wc=rc=1, data in order.
5. Simultaneous read/write:
   - With dc=3, assert write(0x40) and read together for 4 cycles -> dc stays 3, and the 3 old words come out in order followed by 0x40.
   - With dc=0, assert both -> dc=1, dout unchanged.
6. Async reset mid-stream: pulse rst_n low between edges with dc=4 -> outputs clear immediately, empty=1. A subsequent write of 0x55 then read yields dout=0x55.
